// File: rtl/reg_file.sv
// RISC-V integer register file x0..x31 with two combinational read ports.
// Register fields are decoded from the instruction; the write-back source is selected internally.
module reg_file #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_write,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] alu_result,
  input  logic [4:0]      mem_to_reg,
  input  logic [XLEN-1:0] data_mem_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  logic [XLEN-1:0] regs_q [32] = '{default: '0};
  logic [XLEN-1:0] regs_d [32];
  logic [XLEN-1:0] wb_data;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            unused_instr_bits;

  assign rd  = instruction[11:7];
  assign rs1 = instruction[19:15];
  assign rs2 = instruction[24:20];
  assign unused_instr_bits = &{1'b0, instruction[31:25], instruction[14:12], instruction[6:0]};

  // Only the exact code 1 picks memory data; reserved codes fall back to the ALU.
  assign wb_data = (mem_to_reg == 5'd1) ? data_mem_data : alu_result;

  always_comb begin
    regs_d = regs_q;
    if (reg_write && (rd != 5'd0)) begin
      regs_d[rd] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // x0 is forced to zero on the read side so array contents never leak out.
  assign rs1_data = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : regs_q[rs2];

endmodule

// File: tb/tb_reg_file.sv
// Randomised bench for reg_file against an array-based model of the architectural registers.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_write = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic [4:0]  mem_to_reg = 5'd0;
  logic [31:0] data_mem_data = 32'h0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [32];

  reg_file #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .reg_write(reg_write), .instruction(instruction),
    .alu_result(alu_result), .mem_to_reg(mem_to_reg), .data_mem_data(data_mem_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expect_reg(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : mdl[idx];
  endfunction

  // One clock edge with the given controls; the model applies the architectural rules.
  task automatic do_write(input logic [4:0] rd_i, input logic [31:0] alu, input logic [31:0] mem,
                          input logic [4:0] sel, input logic we, input logic rst_i);
    logic [31:0] instr;
    instr = $urandom;
    instr[11:7] = rd_i;
    instruction = instr;
    alu_result = alu;
    data_mem_data = mem;
    mem_to_reg = sel;
    reg_write = we;
    rst = rst_i;
    @(posedge clk);
    if (rst_i) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else if (we && rd_i != 5'd0) begin
      mdl[rd_i] = (sel == 5'd1) ? mem : alu;
    end
    @(negedge clk);
    rst = 1'b0;
    reg_write = 1'b0;
    $display("write rd=%0d we=%0b rst=%0b sel=%0d alu=%h mem=%h", rd_i, we, rst_i, sel, alu, mem);
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [4:0] b);
    logic [31:0] instr;
    @(negedge clk);
    instr = $urandom;
    instr[19:15] = a;
    instr[24:20] = b;
    instruction = instr;
    reg_write = 1'b0;
    alu_result = $urandom;
    data_mem_data = $urandom;
    mem_to_reg = 5'($urandom);
    #1;
    check({tag, "_rs1"}, rs1_data, expect_reg(a));
    check({tag, "_rs2"}, rs2_data, expect_reg(b));
    $display("read rs1=x%0d:%h rs2=x%0d:%h", a, rs1_data, b, rs2_data);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    #1;
    check("powerup_x1", rs1_data, 32'h0);
    @(negedge clk);

    // Fill with nonzero values, then a single reset edge must clear everything.
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'h1000 + i, 32'hffff_0000, 5'd0, 1'b1, 1'b0);
    read_check("prefill", 5'd3, 5'd31);
    do_write(5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) read_check("reset_sweep", 5'(i), 5'(31 - i));

    do_write(5'd0, 32'h3, 32'h0, 5'd0, 1'b1, 1'b0);
    read_check("x0_protect", 5'd0, 5'd0);
    do_write(5'd1, 32'h1, 32'h0, 5'd0, 1'b1, 1'b0);
    read_check("alu_x1", 5'd1, 5'd0);
    do_write(5'd2, 32'h2, 32'h0, 5'd0, 1'b1, 1'b0);
    read_check("alu_x2", 5'd2, 5'd1);
    do_write(5'd5, 32'h5, 32'h0, 5'd0, 1'b1, 1'b0);
    do_write(5'd6, 32'h6, 32'h0, 5'd0, 1'b1, 1'b0);
    read_check("b2b", 5'd5, 5'd6);
    check("b2b_x5_const", rs1_data, 32'h5);
    check("b2b_x6_const", rs2_data, 32'h6);
    do_write(5'd7, 32'h12345678, 32'hdeadbeef, 5'd1, 1'b1, 1'b0);
    read_check("mem_x7", 5'd7, 5'd7);
    check("mem_x7_const", rs1_data, 32'hdeadbeef);
    do_write(5'd7, 32'h12345678, 32'hdeadbeef, 5'd4, 1'b1, 1'b0);
    read_check("rsvd_sel_x7", 5'd7, 5'd7);
    check("rsvd_sel_x7_const", rs1_data, 32'h12345678);
    do_write(5'd7, 32'hcafef00d, 32'h0badf00d, 5'd1, 1'b0, 1'b0);
    read_check("we_off_x7", 5'd7, 5'd2);
    do_write(5'd7, 32'h11111111, 32'h22222222, 5'd0, 1'b1, 1'b1);
    read_check("rst_prio_x7", 5'd7, 5'd5);

    // Random mix; a read of the target right before the edge must show the old value.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd_r, sel_r;
      logic we_r, rst_r;
      rd_r = 5'($urandom);
      sel_r = ($urandom_range(0, 1) == 1) ? 5'd1 : 5'($urandom);
      we_r = ($urandom_range(0, 3) != 0);
      rst_r = ($urandom_range(0, 49) == 0);
      read_check("rnd_pre", rd_r, 5'($urandom));
      do_write(rd_r, $urandom, $urandom, sel_r, we_r, rst_r);
      read_check("rnd_post", rd_r, 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
